// File: rtl/video_speed_ctrl_pkg.sv
// Shared types for the video-output / CPU-speed control block: video modes,
// default bus addresses and the speed-switch FSM states.
package video_speed_pkg;

  typedef enum logic [1:0] {
    MODE_M0 = 2'd0,
    MODE_M1 = 2'd1,
    MODE_M2 = 2'd2
  } video_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } speed_state_t;

  localparam logic [7:0]  DEF_SCANDBL_ADDR = 8'h0B;
  localparam logic [15:0] DEF_SPEED_PORT   = 16'h8E3B;

  // VGA off always counts as RGB, whatever the scanline bit says.
  function automatic video_mode_t decode_mode(input logic vga, input logic scan);
    if (!vga)
      return MODE_M0;
    else if (!scan)
      return MODE_M1;
    else
      return MODE_M2;
  endfunction

endpackage

// File: rtl/video_speed_ctrl_debounce.sv
// Key debouncer: a level is accepted once the raw input has been stable for
// DEBOUNCE_CYC cycles; rise/fall are one-cycle pulses aligned with the level change.
module kbd_debounce_edge #(
  parameter logic [15:0] DEBOUNCE_CYC = 16'd1000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic level,
  output logic rise,
  output logic fall
);

  logic        key_q;
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      key_q <= key;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (key != key_q)
        cnt <= '0;
      else if (cnt != DEBOUNCE_CYC)
        cnt <= cnt + 16'd1;
      // The counter saturates, so a long-stable key keeps qualifying without wrapping.
      if (cnt == DEBOUNCE_CYC && key_q != level) begin
        level <= key_q;
        rise  <= key_q;
        fall  <= ~key_q;
      end
    end
  end

endmodule

// File: rtl/video_speed_ctrl.sv
// SCANDBLCTRL / Prism speed port register block with debounced video and turbo
// hotkeys, and a handshake that only applies new CPU speeds at safe boundaries.
module video_speed_ctrl
  import video_speed_pkg::*;
#(
  parameter logic [7:0]  SCANDBL_ADDR   = DEF_SCANDBL_ADDR,
  parameter logic [15:0] SPEED_PORT     = DEF_SPEED_PORT,
  parameter logic [7:0]  INIT_VIDEO     = 8'h00,
  parameter int          SPEED_W        = 4,
  parameter int          TURBO_SPEED    = 3,
  parameter logic [2:0]  HOTKEY_FREQ    = 3'b111,
  parameter bit          SCANLINE_MODE  = 1'b1,
  parameter logic [15:0] DEBOUNCE_CYC   = 16'd1000,
  parameter logic [15:0] SWITCH_TIMEOUT = 16'd4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        a,
  input  logic               iorq_n,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic [7:0]         zxuno_addr,
  input  logic               zxuno_regrd,
  input  logic               zxuno_regwr,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic               oe,
  input  logic               kbd_video_cycle,
  input  logic               kbd_turbo_boost,
  input  logic               turbo_boost_allowed,
  input  logic               speed_switch_ok,
  output logic               vga_enable,
  output logic               scanlines_enable,
  output logic [2:0]         freq_option,
  output logic               csync_option,
  output logic [SPEED_W-1:0] cpu_speed,
  output logic               speed_changing
);

  // SCANDBLCTRL[7:6] always equals speed_reg[1:0] and is read back as req,
  // so only the low six bits need their own storage.
  logic [5:0]         scandbl;
  logic [SPEED_W-1:0] speed_reg;
  logic [SPEED_W-1:0] req;
  logic               turbo;
  speed_state_t       state;
  logic [15:0]        timer;
  video_mode_t        mode;

  logic vid_level, vid_rise, vid_fall;
  logic turbo_level, turbo_rise, turbo_fall;
  logic zx_wr, port_wr, port_ok;
  logic unused_kbd;

  kbd_debounce_edge #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_video_key (
    .clk   (clk),
    .rst   (rst),
    .key   (kbd_video_cycle),
    .level (vid_level),
    .rise  (vid_rise),
    .fall  (vid_fall)
  );

  kbd_debounce_edge #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_turbo_key (
    .clk   (clk),
    .rst   (rst),
    .key   (kbd_turbo_boost),
    .level (turbo_level),
    .rise  (turbo_rise),
    .fall  (turbo_fall)
  );

  assign unused_kbd = &{1'b0, vid_level, vid_fall, turbo_level};

  assign req     = turbo ? SPEED_W'(TURBO_SPEED) : speed_reg;
  assign zx_wr   = zxuno_regwr && (zxuno_addr == SCANDBL_ADDR);
  assign port_wr = !iorq_n && !wr_n && (a == SPEED_PORT);
  assign port_ok = (din >> SPEED_W) == 8'd0;
  assign mode    = decode_mode(scandbl[0], scandbl[1]);

  assign vga_enable       = scandbl[0];
  assign scanlines_enable = scandbl[1];
  assign freq_option      = scandbl[4:2];
  assign csync_option     = scandbl[5];

  always_comb begin
    oe   = 1'b0;
    dout = 8'hFF;
    if (zxuno_regrd && zxuno_addr == SCANDBL_ADDR) begin
      oe   = 1'b1;
      dout = {req[1:0], scandbl};
    end else if (!iorq_n && !rd_n && a == SPEED_PORT) begin
      oe   = 1'b1;
      dout = 8'(req);
    end
  end

  // A decoded bus write wins the cycle; a video hotkey edge landing on it is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      scandbl   <= INIT_VIDEO[5:0];
      speed_reg <= '0;
      turbo     <= 1'b0;
    end else begin
      if (zx_wr) begin
        scandbl   <= din[5:0];
        speed_reg <= SPEED_W'(din[7:6]);
      end else if (port_wr) begin
        if (port_ok)
          speed_reg <= din[SPEED_W-1:0];
      end else if (vid_rise) begin
        case (mode)
          MODE_M0: begin
            scandbl[1:0] <= 2'b01;
            scandbl[4:2] <= HOTKEY_FREQ;
          end
          MODE_M1: begin
            if (SCANLINE_MODE) begin
              scandbl[1] <= 1'b1;
            end else begin
              scandbl[1:0] <= 2'b00;
              scandbl[4:2] <= 3'b000;
            end
          end
          default: begin
            scandbl[1:0] <= 2'b00;
            scandbl[4:2] <= 3'b000;
          end
        endcase
      end

      if (!turbo_boost_allowed)
        turbo <= 1'b0;
      else if (turbo_rise)
        turbo <= 1'b1;
      else if (turbo_fall)
        turbo <= 1'b0;
    end
  end

  // The clock generator only sees cpu_speed change on its safe pulse, or after the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      timer          <= '0;
      cpu_speed      <= '0;
      speed_changing <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != cpu_speed) begin
            state          <= WAIT;
            timer          <= '0;
            speed_changing <= 1'b1;
          end
        end
        WAIT: begin
          if (req == cpu_speed) begin
            state          <= IDLE;
            speed_changing <= 1'b0;
          end else if (speed_switch_ok || timer == SWITCH_TIMEOUT - 16'd1) begin
            cpu_speed      <= req;
            state          <= IDLE;
            speed_changing <= 1'b0;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: begin
          state          <= IDLE;
          speed_changing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_speed_ctrl.sv
// Randomised bench for video_speed_ctrl against a behavioural model of the
// register, hotkey and speed-switch rules, plus directed literal checks.
module tb_video_speed_ctrl;

  localparam int          DEB     = 20;
  localparam int          TO      = 40;
  localparam int          TURBO   = 3;
  localparam int          SPEED_W = 4;
  localparam logic [15:0] PORT    = 16'h8E3B;
  localparam logic [7:0]  ADDR    = 8'h0B;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] a;
  logic iorq_n, rd_n, wr_n;
  logic [7:0] zxuno_addr;
  logic zxuno_regrd, zxuno_regwr;
  logic [7:0] din;
  logic [7:0] dout;
  logic oe;
  logic kbd_video_cycle, kbd_turbo_boost, turbo_boost_allowed, speed_switch_ok;
  logic vga_enable, scanlines_enable, csync_option, speed_changing;
  logic [2:0] freq_option;
  logic [SPEED_W-1:0] cpu_speed;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  video_speed_ctrl #(
    .DEBOUNCE_CYC   (16'(DEB)),
    .SWITCH_TIMEOUT (16'(TO))
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .a                   (a),
    .iorq_n              (iorq_n),
    .rd_n                (rd_n),
    .wr_n                (wr_n),
    .zxuno_addr          (zxuno_addr),
    .zxuno_regrd         (zxuno_regrd),
    .zxuno_regwr         (zxuno_regwr),
    .din                 (din),
    .dout                (dout),
    .oe                  (oe),
    .kbd_video_cycle     (kbd_video_cycle),
    .kbd_turbo_boost     (kbd_turbo_boost),
    .turbo_boost_allowed (turbo_boost_allowed),
    .speed_switch_ok     (speed_switch_ok),
    .vga_enable          (vga_enable),
    .scanlines_enable    (scanlines_enable),
    .freq_option         (freq_option),
    .csync_option        (csync_option),
    .cpu_speed           (cpu_speed),
    .speed_changing      (speed_changing)
  );

  // Behavioural model state: the full 8-bit register, speeds as integers,
  // and per-key "how long has the raw key been stable" bookkeeping.
  bit [7:0] m_vid;
  int       m_speed, m_cpu, m_age;
  bit       m_turbo, m_pending;
  bit       k_last[2];
  int       k_run[2];
  bit       k_level[2], k_rise_p[2], k_fall_p[2];

  function automatic int mReq();
    return m_turbo ? TURBO : m_speed;
  endfunction

  always @(posedge clk) begin
    int  req;
    bit  vr, tr, tf, zx, pw, keyval, accept;
    if (rst) begin
      m_vid = 8'h00; m_speed = 0; m_cpu = 0; m_age = 0;
      m_turbo = 1'b0; m_pending = 1'b0;
      for (int i = 0; i < 2; i++) begin
        k_last[i] = 1'b0; k_run[i] = 1; k_level[i] = 1'b0;
        k_rise_p[i] = 1'b0; k_fall_p[i] = 1'b0;
      end
    end else begin
      req = mReq();
      if (!m_pending) begin
        if (req != m_cpu) begin m_pending = 1'b1; m_age = 0; end
      end else if (req == m_cpu) begin
        m_pending = 1'b0;
      end else if (speed_switch_ok || m_age == TO - 1) begin
        m_cpu = req; m_pending = 1'b0;
      end else begin
        m_age++;
      end

      vr = k_rise_p[0]; tr = k_rise_p[1]; tf = k_fall_p[1];
      zx = zxuno_regwr && zxuno_addr == ADDR;
      pw = !iorq_n && !wr_n && a == PORT;
      if (zx) begin
        m_vid = din; m_speed = int'(din[7:6]);
      end else if (pw) begin
        if (din[7:4] == 4'd0) begin m_speed = int'(din[3:0]); m_vid[7:6] = din[1:0]; end
      end else if (vr) begin
        if (!m_vid[0]) begin m_vid[1:0] = 2'b01; m_vid[4:2] = 3'b111; end
        else if (!m_vid[1]) m_vid[1] = 1'b1;
        else begin m_vid[1:0] = 2'b00; m_vid[4:2] = 3'b000; end
      end

      if (!turbo_boost_allowed) m_turbo = 1'b0;
      else if (tr) m_turbo = 1'b1;
      else if (tf) m_turbo = 1'b0;

      for (int i = 0; i < 2; i++) begin
        keyval = (i == 0) ? kbd_video_cycle : kbd_turbo_boost;
        accept = (k_run[i] >= DEB + 1) && (k_last[i] != k_level[i]);
        k_rise_p[i] = accept && k_last[i];
        k_fall_p[i] = accept && !k_last[i];
        if (accept) k_level[i] = k_last[i];
        if (keyval == k_last[i]) begin
          if (k_run[i] < DEB + 1) k_run[i]++;
        end else begin
          k_last[i] = keyval; k_run[i] = 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    int       req;
    bit       exp_oe;
    bit [7:0] exp_dout;
    if (chk_en) begin
      req = mReq();
      exp_oe = 1'b0; exp_dout = 8'hFF;
      if (zxuno_regrd && zxuno_addr == ADDR) begin
        exp_oe = 1'b1; exp_dout = {2'(req), m_vid[5:0]};
      end else if (!iorq_n && !rd_n && a == PORT) begin
        exp_oe = 1'b1; exp_dout = 8'(req);
      end
      checkOutput("model_vga",       32'(vga_enable),       32'(m_vid[0]));
      checkOutput("model_scan",      32'(scanlines_enable), 32'(m_vid[1]));
      checkOutput("model_freq",      32'(freq_option),      32'(m_vid[4:2]));
      checkOutput("model_csync",     32'(csync_option),     32'(m_vid[5]));
      checkOutput("model_cpu_speed", 32'(cpu_speed),        32'(m_cpu));
      checkOutput("model_changing",  32'(speed_changing),   32'(m_pending));
      checkOutput("model_oe",        32'(oe),               32'(exp_oe));
      checkOutput("model_dout",      32'(dout),             32'(exp_dout));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleBus();
    a = 16'h0000; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    zxuno_addr = 8'h00; zxuno_regrd = 1'b0; zxuno_regwr = 1'b0;
    din = 8'h00; speed_switch_ok = 1'b0;
  endtask

  task automatic zxWrite(input logic [7:0] d);
    zxuno_regwr = 1'b1; zxuno_addr = ADDR; din = d;
    tick();
    idleBus();
  endtask

  task automatic portWrite(input logic [7:0] d);
    iorq_n = 1'b0; wr_n = 1'b0; a = PORT; din = d;
    tick();
    idleBus();
  endtask

  task automatic readZx(input string name, input logic [7:0] expected);
    zxuno_regrd = 1'b1; zxuno_addr = ADDR;
    #1;
    checkOutput({name, "_oe"}, 32'(oe), 32'd1);
    checkOutput(name, 32'(dout), 32'(expected));
    zxuno_regrd = 1'b0;
  endtask

  task automatic readPort(input string name, input logic [7:0] expected);
    iorq_n = 1'b0; rd_n = 1'b0; a = PORT;
    #1;
    checkOutput({name, "_oe"}, 32'(oe), 32'd1);
    checkOutput(name, 32'(dout), 32'(expected));
    iorq_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic checkVideo(input string name, input logic vga, input logic scan, input logic [2:0] freq);
    checkOutput({name, "_vga"},  32'(vga_enable),       32'(vga));
    checkOutput({name, "_scan"}, 32'(scanlines_enable), 32'(scan));
    checkOutput({name, "_freq"}, 32'(freq_option),      32'(freq));
  endtask

  task automatic pressVideo();
    kbd_video_cycle = 1'b1;
    repeat (DEB + 3) tick();
    kbd_video_cycle = 1'b0;
  endtask

  task automatic applyStimulus(input int cycles);
    int r;
    for (int n = 0; n < cycles; n++) begin
      idleBus();
      r = $urandom_range(0, 99);
      if (r < 4) begin
        zxuno_regwr = 1'b1;
        zxuno_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ADDR;
        din = 8'($urandom);
        if ($urandom_range(0, 3) == 0) begin iorq_n = 1'b0; wr_n = 1'b0; a = PORT; end
      end else if (r < 9) begin
        iorq_n = 1'b0; wr_n = 1'b0;
        a = ($urandom_range(0, 4) == 0) ? 16'($urandom) : PORT;
        din = $urandom_range(0, 1) ? {4'd0, 4'($urandom)} : 8'($urandom);
      end else if (r < 20) begin
        zxuno_regrd = 1'b1;
        zxuno_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ADDR;
      end else if (r < 30) begin
        iorq_n = 1'b0; rd_n = 1'b0;
        a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : PORT;
      end
      speed_switch_ok = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 39) == 0) kbd_video_cycle = ~kbd_video_cycle;
      if ($urandom_range(0, 49) == 0) kbd_turbo_boost = ~kbd_turbo_boost;
      if ($urandom_range(0, 199) == 0) turbo_boost_allowed = ~turbo_boost_allowed;
      rst = ($urandom_range(0, 1499) == 0);
      tick();
    end
    idleBus();
    rst = 1'b0;
  endtask

  initial begin
    idleBus();
    rst = 1'b1;
    kbd_video_cycle = 1'b0; kbd_turbo_boost = 1'b0; turbo_boost_allowed = 1'b1;
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_cpu_speed", 32'(cpu_speed), 32'd0);
    checkOutput("rst_changing", 32'(speed_changing), 32'd0);
    checkVideo("rst", 1'b0, 1'b0, 3'b000);
    checkOutput("rst_csync", 32'(csync_option), 32'd0);
    checkOutput("rst_oe", 32'(oe), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'hFF);

    $display("[TB] ZX-Uno write and speed switch on safe pulse");
    zxWrite(8'hC5);
    checkVideo("wr_c5", 1'b1, 1'b0, 3'b001);
    checkOutput("wr_c5_csync", 32'(csync_option), 32'd0);
    tick();
    checkOutput("wr_c5_changing", 32'(speed_changing), 32'd1);
    readZx("wr_c5_read", 8'hC5);
    repeat (9) tick();
    speed_switch_ok = 1'b1;
    tick();
    speed_switch_ok = 1'b0;
    checkOutput("switch_ok_cpu", 32'(cpu_speed), 32'd3);
    checkOutput("switch_ok_changing", 32'(speed_changing), 32'd0);

    $display("[TB] speed port writes");
    portWrite(8'h12);
    readPort("port_ignored_read", 8'h03);
    portWrite(8'h02);
    readPort("port_02_read", 8'h02);
    readZx("port_02_zxread", 8'h85);
    tick();
    speed_switch_ok = 1'b1;
    tick();
    speed_switch_ok = 1'b0;
    checkOutput("port_02_cpu", 32'(cpu_speed), 32'd2);

    $display("[TB] video hotkey cycling");
    zxWrite(8'h80);
    checkVideo("m0_start", 1'b0, 1'b0, 3'b000);
    pressVideo();
    checkVideo("hot_m1", 1'b1, 1'b0, 3'b111);
    repeat (DEB + 3) tick();
    pressVideo();
    checkVideo("hot_m2", 1'b1, 1'b1, 3'b111);
    repeat (DEB + 3) tick();
    pressVideo();
    checkVideo("hot_m0", 1'b0, 1'b0, 3'b000);
    repeat (DEB + 3) tick();
    kbd_video_cycle = 1'b1;
    repeat (5) tick();
    kbd_video_cycle = 1'b0;
    repeat (DEB + 3) tick();
    checkVideo("glitch", 1'b0, 1'b0, 3'b000);

    $display("[TB] turbo hold and timeout switch");
    kbd_turbo_boost = 1'b1;
    repeat (DEB + 3) tick();
    readPort("turbo_read", 8'(TURBO));
    turbo_boost_allowed = 1'b0;
    tick();
    readPort("turbo_drop_read", 8'h02);
    kbd_turbo_boost = 1'b0;
    portWrite(8'h05);
    repeat (TO) tick();
    checkOutput("timeout_before_cpu", 32'(cpu_speed), 32'd2);
    checkOutput("timeout_before_changing", 32'(speed_changing), 32'd1);
    tick();
    checkOutput("timeout_cpu", 32'(cpu_speed), 32'd5);
    checkOutput("timeout_changing", 32'(speed_changing), 32'd0);

    $display("[TB] write colliding with hotkey edge, reset mid-wait");
    kbd_video_cycle = 1'b1;
    repeat (DEB + 2) tick();
    zxWrite(8'h61);
    kbd_video_cycle = 1'b0;
    checkVideo("collide", 1'b1, 1'b0, 3'b000);
    checkOutput("collide_csync", 32'(csync_option), 32'd1);
    repeat (DEB + 3) tick();
    checkVideo("collide_after", 1'b1, 1'b0, 3'b000);
    checkOutput("midwait_changing", 32'(speed_changing), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midwait_rst_cpu", 32'(cpu_speed), 32'd0);
    checkOutput("midwait_rst_changing", 32'(speed_changing), 32'd0);
    checkVideo("midwait_rst", 1'b0, 1'b0, 3'b000);

    $display("[TB] randomised traffic");
    turbo_boost_allowed = 1'b1;
    applyStimulus(3000);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
